// File: rtl/bus_protocol_rr_arbiter_pkg.sv
// Shared types for the bus arbiter: the common bus word and arbiter-local
// types (FSM states, strobe width).
package phy_types_pkg;
    typedef logic [31:0] word_t;
endpackage

package bus_arb_pkg;
    typedef phy_types_pkg::word_t word_t;

    localparam int STROBE_W = 4;
    typedef logic [STROBE_W-1:0] strobe_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;
endpackage

// File: rtl/bus_protocol_rr_arbiter_if.sv
// Requester-side register/memory bus. The protocol side issues ren/wen with
// addr/wdata/strobe and holds them until request_stall drops.
interface bus_protocol_if;
    import bus_arb_pkg::*;

    word_t   addr;
    word_t   wdata;
    word_t   rdata;
    strobe_t strobe;
    logic    ren;
    logic    wen;
    logic    request_stall;
    logic    error;

    // Requester (master) view: drives the request, samples the response.
    modport protocol (
        output addr, wdata, strobe, ren, wen,
        input  request_stall, rdata, error
    );

    // Slave view: samples the request, drives the response.
    modport peripheral (
        input  addr, wdata, strobe, ren, wen,
        output request_stall, rdata, error
    );
endinterface

// File: rtl/bus_protocol_rr_arbiter_counter.sv
// Generic up-counter with synchronous clear (clear wins over enable).
module socetlib_counter #(
    parameter int NBITS = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    output logic [NBITS-1:0] count_out
);
    logic [NBITS-1:0] count_q;

    // Count register: async reset, then clear, then increment.
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
        if (!n_rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_enable) begin
            count_q <= count_q + NBITS'(1);
        end
    end

    assign count_out = count_q;
endmodule

// File: rtl/bus_protocol_rr_arbiter_picker.sv
// Round-robin priority picker: finds the first active requester after
// last_grant_i, wrapping modulo NUM_REQ.
module rr_priority_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] active_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               valid_o
);
    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate to the nearest so the nearest active
    // requester after last_grant_i is the one that sticks.
    always_comb begin
        // NOTE: every output gets a default before the search loop so no latch is inferred.
        grant_o = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = IDX_W'((int'(last_grant_i) + off) % NUM_REQ);
            if (active_i[cand]) begin
                grant_o = cand;
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_protocol_rr_arbiter.sv
// Round-robin arbiter sharing one downstream bus_protocol_if among NUM_REQ
// requesters. A grant is held for the whole transaction and released on
// completion, abort, illegal request (ren and wen together) or stall timeout.
module bus_protocol_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [NUM_REQ-1:0]           req_ren,
    input  logic [NUM_REQ-1:0]           req_wen,
    input  word_t [NUM_REQ-1:0]          req_addr,
    input  word_t [NUM_REQ-1:0]          req_wdata,
    input  strobe_t [NUM_REQ-1:0]        req_strobe,
    output logic [NUM_REQ-1:0]           req_stall,
    output logic [NUM_REQ-1:0]           req_error,
    output word_t                        req_rdata,
    bus_protocol_if.protocol             out_if,
    output logic [$clog2(NUM_REQ)-1:0]   grant_idx
);
    localparam int               IDX_W        = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_REQ - 1);
    localparam logic [15:0]      TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;

    logic [NUM_REQ-1:0] active;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [15:0]        stall_cnt;
    logic               cnt_clear;
    logic               cnt_enable;
    logic               timeout_hit;
    logic               g_ren, g_wen;
    logic               release_bus;

    assign active    = req_ren | req_wen;
    assign g_ren     = req_ren[grant_q];
    assign g_wen     = req_wen[grant_q];
    assign grant_idx = grant_q;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .active_i     (active),
        .last_grant_i (last_q),
        .grant_o      (pick_idx),
        .valid_o      (pick_valid)
    );

    // Watchdog counts consecutive stalled BUSY cycles; held at zero in IDLE.
    assign cnt_clear   = (state_q == IDLE);
    assign cnt_enable  = (state_q == BUSY) && out_if.request_stall;
    assign timeout_hit = (stall_cnt == TIMEOUT_LAST);

    socetlib_counter #(
        .NBITS (16)
    ) u_timeout (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (cnt_enable),
        .count_out    (stall_cnt)
    );

    // FSM state, current grant and round-robin pointer; requester 0 wins first after reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_IDX;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Next state, downstream mux and per-requester responses.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        release_bus   = 1'b0;
        req_stall     = '1;
        req_error     = '0;
        req_rdata     = '0;
        out_if.addr   = '0;
        out_if.wdata  = '0;
        out_if.strobe = '0;
        out_if.ren    = 1'b0;
        out_if.wen    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                out_if.addr   = req_addr[grant_q];
                out_if.wdata  = req_wdata[grant_q];
                out_if.strobe = req_strobe[grant_q];
                out_if.ren    = g_ren;
                out_if.wen    = g_wen;
                req_rdata     = out_if.rdata;

                if (g_ren && g_wen) begin
                    // Illegal request: keep it off the bus, fail it locally.
                    out_if.ren         = 1'b0;
                    out_if.wen         = 1'b0;
                    req_stall[grant_q] = 1'b0;
                    req_error[grant_q] = 1'b1;
                    release_bus        = 1'b1;
                end else if (!(g_ren || g_wen)) begin
                    // Requester withdrew: release silently.
                    release_bus = 1'b1;
                end else if (!out_if.request_stall) begin
                    req_stall[grant_q] = 1'b0;
                    req_error[grant_q] = out_if.error;
                    release_bus        = 1'b1;
                end else if (timeout_hit) begin
                    // Hung slave: drop the enables and force an error completion.
                    out_if.ren         = 1'b0;
                    out_if.wen         = 1'b0;
                    req_stall[grant_q] = 1'b0;
                    req_error[grant_q] = 1'b1;
                    release_bus        = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        // Every exit from BUSY advances the pointer so no requester is starved.
        if (release_bus) begin
            state_d = IDLE;
            last_d  = grant_q;
        end
    end
endmodule

// File: tb/tb_bus_protocol_rr_arbiter.sv
// Directed bench for bus_protocol_rr_arbiter (3 requesters, 16-cycle timeout).
// Completions are checked by a scoreboard monitor; cycle-level details are
// checked inline by the stimulus.
module tb_bus_protocol_rr_arbiter;
    import bus_arb_pkg::*;

    localparam int    NREQ = 3;
    localparam int    TMO  = 16;
    localparam word_t RKEY = 32'h5A5A_0000;

    typedef struct {
        int    idx;
        logic  err;
        word_t rdata;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 n_rst;
    logic [NREQ-1:0]      req_ren, req_wen;
    word_t [NREQ-1:0]     req_addr, req_wdata;
    strobe_t [NREQ-1:0]   req_strobe;
    logic [NREQ-1:0]      req_stall, req_error;
    word_t                req_rdata;
    logic [1:0]           grant_idx;

    int   n_vec = 0;
    int   n_err = 0;
    int   slave_wait;
    int   busy_cyc;
    exp_t exp_q[$];

    bus_protocol_if bus();

    bus_protocol_rr_arbiter #(
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .req_ren    (req_ren),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_strobe (req_strobe),
        .req_stall  (req_stall),
        .req_error  (req_error),
        .req_rdata  (req_rdata),
        .out_if     (bus),
        .grant_idx  (grant_idx)
    );

    always #5 clk = ~clk;

    // Slave model: stalls the first slave_wait cycles of each enabled transfer.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst)                busy_cyc <= 0;
        else if (bus.ren || bus.wen) busy_cyc <= busy_cyc + 1;
        else                       busy_cyc <= 0;
    end
    assign bus.request_stall = (busy_cyc < slave_wait);
    assign bus.rdata         = bus.addr ^ RKEY;
    assign bus.error         = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic err, input word_t addr);
        exp_t e;
        e.idx   = idx;
        e.err   = err;
        e.rdata = addr ^ RKEY;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"},  32'(req_stall), 32'h7);
        check({tag, "_error"},  32'(req_error), 32'h0);
        check({tag, "_ren"},    32'(bus.ren), 32'h0);
        check({tag, "_wen"},    32'(bus.wen), 32'h0);
        check({tag, "_addr"},   bus.addr, 32'h0);
        check({tag, "_wdata"},  bus.wdata, 32'h0);
        check({tag, "_strobe"}, 32'(bus.strobe), 32'h0);
        check({tag, "_rdata"},  req_rdata, 32'h0);
        check({tag, "_grant"},  32'(grant_idx), 32'h0);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        n_rst = 1'b1;
    endtask

    // Scoreboard monitor: every req_stall=0 pulse must match the next expected completion.
    always @(negedge clk) begin
        exp_t e;
        if (n_rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_stall[i]) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL completion: unexpected pulse idx=%0d err=%0b", i, req_error[i]);
                    end else begin
                        e = exp_q.pop_front();
                        if (i != e.idx || req_error[i] !== e.err || req_rdata !== e.rdata) begin
                            n_err++;
                            $display("FAIL completion: got idx=%0d err=%0b rdata=%08h, expected idx=%0d err=%0b rdata=%08h",
                                     i, req_error[i], req_rdata, e.idx, e.err, e.rdata);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: run exceeded 50000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst      = 1'b0;
        req_ren    = '0;
        req_wen    = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_strobe = '0;
        slave_wait = 0;
        step();
        do_reset();

        // Single write, slave stalls 2 cycles: done on the 3rd BUSY cycle.
        slave_wait    = 2;
        req_wen[0]    = 1'b1;
        req_addr[0]   = 32'h0000_1000;
        req_wdata[0]  = 32'hDEAD_BEEF;
        req_strobe[0] = 4'hF;
        push_exp(0, 1'b0, 32'h0000_1000);
        @(negedge clk);
        check("wr_idle_wen", 32'(bus.wen), 32'h0);
        step();
        @(negedge clk);
        check("wr_busy_wen",   32'(bus.wen), 32'h1);
        check("wr_busy_addr",  bus.addr, 32'h0000_1000);
        check("wr_busy_wdata", bus.wdata, 32'hDEAD_BEEF);
        check("wr_busy_strb",  32'(bus.strobe), 32'hF);
        check("wr_busy_stall", 32'(req_stall), 32'h7);
        step();
        step();
        step();
        req_wen[0] = 1'b0;
        @(negedge clk);
        check("wr_done_state", 32'(dut.state_q), 32'(IDLE));
        check("wr_done_wen",   32'(bus.wen), 32'h0);

        // Post-reset contention, zero-wait slave: 0 then 1, two cycles apart.
        do_reset();
        slave_wait  = 0;
        req_ren     = 3'b011;
        req_addr[0] = 32'h0000_2000;
        req_addr[1] = 32'h0000_2004;
        push_exp(0, 1'b0, 32'h0000_2000);
        push_exp(1, 1'b0, 32'h0000_2004);
        step();
        @(negedge clk);
        check("cont_grant0", 32'(grant_idx), 32'h0);
        step();
        req_ren[0] = 1'b0;
        step();
        @(negedge clk);
        check("cont_grant1", 32'(grant_idx), 32'h1);
        step();
        req_ren[1] = 1'b0;

        // Fairness: all three hold requests for 9 transactions.
        do_reset();
        req_ren     = 3'b111;
        req_addr[0] = 32'h0000_0100;
        req_addr[1] = 32'h0000_0200;
        req_addr[2] = 32'h0000_0300;
        for (int k = 0; k < 9; k++) push_exp(k % 3, 1'b0, 32'(((k % 3) + 1) * 256));
        for (int k = 0; k < 9; k++) begin
            step();
            @(negedge clk);
            check("fair_grant", 32'(grant_idx), 32'(k % 3));
            step();
        end
        req_ren = '0;

        // Timeout: slave hangs, forced error on the 16th BUSY cycle.
        slave_wait  = 1000;
        req_ren[1]  = 1'b1;
        req_addr[1] = 32'h0000_3000;
        push_exp(1, 1'b1, 32'h0000_3000);
        step();
        @(negedge clk);
        check("tmo_busy_ren", 32'(bus.ren), 32'h1);
        check("tmo_grant",    32'(grant_idx), 32'h1);
        for (int k = 2; k <= 16; k++) step();
        @(negedge clk);
        check("tmo_ren_drop", 32'(bus.ren), 32'h0);
        step();
        req_ren[1] = 1'b0;
        @(negedge clk);
        check("tmo_state", 32'(dut.state_q), 32'(IDLE));

        // Abort: granted requester 2 withdraws mid-stall; requester 0 follows.
        req_ren     = 3'b101;
        req_addr[0] = 32'h0000_5000;
        push_exp(0, 1'b0, 32'h0000_5000);
        step();
        @(negedge clk);
        check("abort_grant2", 32'(grant_idx), 32'h2);
        step();
        req_ren[2] = 1'b0;
        @(negedge clk);
        check("abort_stall", 32'(req_stall), 32'h7);
        check("abort_error", 32'(req_error), 32'h0);
        step();
        slave_wait = 1;
        @(negedge clk);
        check("abort_state", 32'(dut.state_q), 32'(IDLE));
        step();
        @(negedge clk);
        check("abort_grant0", 32'(grant_idx), 32'h0);
        step();
        step();
        req_ren[0] = 1'b0;

        // Illegal request: ren and wen together from requester 1.
        slave_wait  = 0;
        req_ren[1]  = 1'b1;
        req_wen[1]  = 1'b1;
        req_addr[1] = 32'h0000_4000;
        push_exp(1, 1'b1, 32'h0000_4000);
        step();
        @(negedge clk);
        check("ill_ren", 32'(bus.ren), 32'h0);
        check("ill_wen", 32'(bus.wen), 32'h0);
        step();
        req_ren[1] = 1'b0;
        req_wen[1] = 1'b0;
        @(negedge clk);
        check("ill_state", 32'(dut.state_q), 32'(IDLE));

        // Reset while BUSY with the slave stalled.
        slave_wait  = 1000;
        req_ren[2]  = 1'b1;
        step();
        step();
        #1;
        n_rst      = 1'b0;
        req_ren[0] = 1'b1;
        #1;
        check_reset_outputs("midrst");
        check("midrst_state", 32'(dut.state_q), 32'(IDLE));
        step();
        step();
        n_rst      = 1'b1;
        slave_wait = 0;
        push_exp(0, 1'b0, 32'h0000_5000);
        push_exp(2, 1'b0, 32'h0000_0300);
        step();
        @(negedge clk);
        check("midrst_grant0", 32'(grant_idx), 32'h0);
        step();
        req_ren[0] = 1'b0;
        step();
        @(negedge clk);
        check("midrst_grant2", 32'(grant_idx), 32'h2);
        step();
        req_ren[2] = 1'b0;
        step();
        step();

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
